conv3x3_window_gen: RTL and testbench
=====================================

CONV3X3_WINDOW_GEN -- requirements
Module: conv3x3_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one FP32 pixel word.
REQ-002 SHALL have parameter IMG_SIZE, default 104: feature-map width and height N (square, N >= 3).
REQ-003 SHALL have port Clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, DATA_WIDTH: one pixel, raster order (row-major, row 0 first).
REQ-006 SHALL have port valid_in, input, 1: data_in accepted on a rising edge when valid_in=1 and ready_out=1.
REQ-007 SHALL have port ready_out, output, 1: block can accept a pixel this cycle.
REQ-008 SHALL have port window_out, output, 9*DATA_WIDTH: 3x3 window, element k (k=0..8) at bits [DATA_WIDTH*k+DATA_WIDTH-1 : DATA_WIDTH*k], row-major, k=0 top-left, k=4 centre, k=8 bottom-right (matches Conv2D3x3 w0..w8 order).
REQ-009 SHALL have port valid_out, output, 1: window_out valid for one cycle.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse with the last window of a frame.

Function
REQ-011 SHALL emit exactly N*N windows per frame, one per centre pixel (r,c), r,c in 0..N-1, in raster order of centre (stride 1, same-size output).
REQ-012 SHALL set element k of the window for centre (r,c) to pixel (r-1+k/3, c-1+k%3), or to zero (all DATA_WIDTH bits 0) when that row or column is outside 0..N-1 (zero padding of 1).
REQ-013 SHALL store the last 2N+3 accepted pixels in a shift buffer (two line buffers plus taps); buffer contents are not reset, padding is applied by masking on the centre counters only.
REQ-014 SHALL use FSM states IDLE, RUN, FLUSH: IDLE -> RUN on first accepted pixel of a frame; RUN -> FLUSH when pixel index N*N-1 is accepted; FLUSH -> IDLE after the last window (centre N-1,N-1) is emitted.
REQ-015 SHALL drive ready_out=1 in IDLE and RUN and ready_out=0 in FLUSH; valid_in during FLUSH is ignored.
REQ-016 SHALL, in RUN, emit the window for centre index p-(N+1) on the cycle after input pixel index p is accepted, for p >= N+1 (registered output, latency 1 cycle from the enabling acceptance).
REQ-017 SHALL, in FLUSH, shift one zero word per cycle and emit one window per cycle for centres N*N-N-1 .. N*N-1 (N+1 windows, N+1 consecutive cycles, no bubbles).
REQ-018 SHALL keep valid_out=0 on cycles without an emission; window_out holds its last value then.
REQ-019 SHALL track the input pixel index and centre row/column with counters of width clog2(N*N) / clog2(N); column counters wrap N-1 -> 0 and increment row.
REQ-020 SHALL assert frame_done together with valid_out for centre (N-1,N-1) only.
REQ-021 SHALL accept gaps in valid_in in RUN without emitting and without losing state; a pixel arriving on the first cycle after returning to IDLE starts a new frame at index 0.

Reset
REQ-022 SHALL, on Rst=1 (asynchronous), force state IDLE, all counters 0, valid_out=0, frame_done=0, window_out=0, ready_out=1.
REQ-023 SHALL, on reset mid-frame or mid-FLUSH, discard the partial frame; the first pixel accepted after Rst deasserts is pixel (0,0) of a new frame.

Verification (N=4, pixel value = index+1, i.e. 1..16)
REQ-024 SHALL verify: 16 back-to-back pixels -> first valid_out the cycle after pixel 6 accepted, window = 0,0,0,0,1,2,0,5,6.
REQ-025 SHALL verify: same frame -> window for centre (1,1) = 1,2,3,5,6,7,9,10,11; for centre (3,3) = 11,12,0,15,16,0,0,0,0 with frame_done=1; 16 valid_out pulses in total.
REQ-026 SHALL verify: after pixel 16 accepted -> ready_out=0 for exactly 5 cycles, valid_out=1 on each, then ready_out=1 in IDLE.
REQ-027 SHALL verify: valid_in toggled 1,0,1,0 through the frame -> identical 16 windows in the same order, none emitted on idle cycles.
REQ-028 SHALL verify: Rst asserted after pixel 9 accepted, then a full new frame of values 101..116 -> first window = 0,0,0,0,101,102,0,105,106, no stale values from the aborted frame.
REQ-029 SHALL verify: two frames back-to-back (second starts the cycle after FLUSH ends) -> 32 windows, second frame's window for centre (0,0) equals 0,0,0,0,1,2,0,5,6.

Source files
------------

// File: rtl/conv3x3_window_gen_if.sv
// Pixel-stream / window handshake bundle for conv3x3_window_gen.
// The master drives pixels in; the slave (the window generator) returns 3x3 windows.
interface conv3x3_window_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [9*DATA_WIDTH-1:0] window_out;
    logic                    valid_out;
    logic                    frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  window_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output window_out,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/conv3x3_window_gen.sv
// 3x3 sliding-window generator with zero padding of 1 over a square NxN raster frame.
// Emits N*N same-size windows, one per centre pixel, in raster order.
module conv3x3_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    conv3x3_window_gen_if.slave   bus
);

    localparam int unsigned NN      = IMG_SIZE * IMG_SIZE;
    localparam int unsigned PIX_W   = $clog2(NN);
    localparam int unsigned RC_W    = $clog2(IMG_SIZE);
    localparam int unsigned BUF_LEN = 2 * IMG_SIZE + 3;
    localparam int unsigned BUF_W   = BUF_LEN * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [PIX_W-1:0]        r_pix_idx;
    logic [RC_W-1:0]         r_crow;
    logic [RC_W-1:0]         r_ccol;
    logic [BUF_W-1:0]        r_buf;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_shift;
    logic                    w_emit;
    logic                    w_last_pix;
    logic                    w_last_ctr;
    logic                    w_past_lead;
    logic [DATA_WIDTH-1:0]   w_shift_in;
    logic [BUF_W-1:0]        w_next_buf;
    logic [9*DATA_WIDTH-1:0] w_window;
    logic [8:0]              w_pad;
    logic                    w_row_top;
    logic                    w_row_bot;
    logic                    w_col_lft;
    logic                    w_col_rgt;

    assign w_last_pix  = (r_pix_idx == PIX_W'(NN - 1));
    assign w_past_lead = (r_pix_idx >= PIX_W'(IMG_SIZE + 1));
    assign w_last_ctr  = (r_crow == RC_W'(IMG_SIZE - 1)) && (r_ccol == RC_W'(IMG_SIZE - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_emit      = 1'b0;
        w_shift_in  = bus.data_in;
        unique case (r_state)
            IDLE: begin
                w_accept = bus.valid_in;
                w_shift  = w_accept;
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_accept = bus.valid_in;
                w_shift  = w_accept;
                w_emit   = w_accept && w_past_lead;
                if (w_accept && w_last_pix) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_ready    = 1'b0;
                w_shift    = 1'b1;
                w_emit     = 1'b1;
                w_shift_in = '0;
                if (w_last_ctr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ready_out = w_ready;

    // Slot 0 is the newest pixel; the window is tapped from the post-shift view so
    // the registered output lands one cycle after the enabling acceptance.
    assign w_next_buf = {r_buf[BUF_W-DATA_WIDTH-1:0], w_shift_in};

    always_ff @(posedge Clk) begin
        if (w_shift) begin
            r_buf <= w_next_buf;
        end
    end

    assign w_row_top = (r_crow == '0);
    assign w_row_bot = (r_crow == RC_W'(IMG_SIZE - 1));
    assign w_col_lft = (r_ccol == '0);
    assign w_col_rgt = (r_ccol == RC_W'(IMG_SIZE - 1));

    // Element k maps to buffer slot (N+1) - (k/3-1)*N - (k%3-1) relative to the newest pixel.
    for (genvar k = 0; k < 9; k++) begin : g_tap
        localparam int unsigned DR  = k / 3;
        localparam int unsigned DC  = k % 3;
        localparam int unsigned POS = 2 * IMG_SIZE + 2 - DR * IMG_SIZE - DC;

        assign w_pad[k] = ((DR == 0) && w_row_top) || ((DR == 2) && w_row_bot) ||
                          ((DC == 0) && w_col_lft) || ((DC == 2) && w_col_rgt);
        assign w_window[k*DATA_WIDTH +: DATA_WIDTH] =
            w_pad[k] ? '0 : w_next_buf[POS*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pix_idx      <= '0;
            r_crow         <= '0;
            r_ccol         <= '0;
            bus.window_out <= '0;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= w_emit;
            bus.frame_done <= w_emit && w_last_ctr;

            if (w_accept) begin
                r_pix_idx <= w_last_pix ? '0 : r_pix_idx + 1'b1;
            end

            if (w_emit) begin
                bus.window_out <= w_window;
                if (r_ccol == RC_W'(IMG_SIZE - 1)) begin
                    r_ccol <= '0;
                    r_crow <= w_row_bot ? '0 : r_crow + 1'b1;
                end else begin
                    r_ccol <= r_ccol + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Scoreboard bench for conv3x3_window_gen at N=4: expected windows are queued as
// frames are driven and compared as the DUT emits them.
module tb_conv3x3_window_gen;

    localparam int DW   = 32;
    localparam int N    = 4;
    localparam int NPIX = N * N;
    localparam int WW   = 9 * DW;

    typedef struct {
        logic [WW-1:0] win;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb[$];
    exp_t m_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_win   = 0;
    int   w0;

    conv3x3_window_gen_if #(.DATA_WIDTH(DW)) bus ();

    conv3x3_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_SIZE   (N)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] model_win(input int base, input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            int rr;
            int cc;
            rr = r - 1 + k / 3;
            cc = c - 1 + k % 3;
            if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                w[k*DW +: DW] = DW'(base + rr * N + cc);
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int base, input int count);
        exp_t t;
        for (int q = 0; q < count; q++) begin
            t.win = model_win(base, q / N, q % N);
            t.fd  = (q == NPIX - 1);
            sb.push_back(t);
        end
    endtask

    // Called on a negedge; leaves the caller on the negedge after the last acceptance
    // (or after the trailing gap cycle when gaps are enabled).
    task automatic drive_frame(input int base, input bit gaps, input int npix, input bit lat_chk);
        for (int i = 0; i < npix; i++) begin
            int guard;
            guard = 0;
            while (!bus.ready_out && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("ready_wait", bus.ready_out, 1);
            if (lat_chk && i == 5) check("no_early_valid", bus.valid_out, 0);
            if (lat_chk && i == 6) check("first_valid_latency", bus.valid_out, 1);
            bus.data_in  = DW'(base + i);
            bus.valid_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (gaps) begin
                bus.valid_in = 1'b0;
                @(posedge clk);
                @(negedge clk);
                if (i < npix - 1) check("gap_no_emit", bus.valid_out, 0);
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic check_flush();
        int low;
        low = 0;
        for (int c = 0; c < 10 && !bus.ready_out; c++) begin
            low++;
            check("flush_valid", bus.valid_out, 1);
            @(negedge clk);
        end
        check("flush_len", low, 5);
        check("idle_ready", bus.ready_out, 1);
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.ready_out && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("idle_wait", bus.ready_out, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out) begin
                n_win++;
                if (sb.size() == 0) begin
                    check("unexpected_window", bus.valid_out, 0);
                end else begin
                    m_exp = sb.pop_front();
                    check("window", bus.window_out, m_exp.win);
                    check("frame_done", bus.frame_done, m_exp.fd);
                end
            end else begin
                check("frame_done_idle", bus.frame_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready_out, 1);
        check("rst_valid", bus.valid_out, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_window", bus.window_out, '0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back single frame
        w0 = n_win;
        push_frame(1, NPIX);
        drive_frame(1, 1'b0, NPIX, 1'b1);
        check_flush();
        @(posedge clk);
        check("frame1_count", n_win - w0, NPIX);
        repeat (3) @(negedge clk);

        // valid_in toggling every cycle
        w0 = n_win;
        push_frame(1, NPIX);
        drive_frame(1, 1'b1, NPIX, 1'b0);
        wait_ready();
        @(posedge clk);
        check("gap_frame_count", n_win - w0, NPIX);
        repeat (2) @(negedge clk);

        // abort after nine pixels, then a fresh frame
        push_frame(1, 4);
        drive_frame(1, 1'b0, 9, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ready", bus.ready_out, 1);
        check("abort_valid", bus.valid_out, 0);
        check("abort_window", bus.window_out, '0);
        check("abort_sb_drained", sb.size(), 0);
        rst = 1'b0;
        @(negedge clk);
        w0 = n_win;
        push_frame(101, NPIX);
        drive_frame(101, 1'b0, NPIX, 1'b1);
        check_flush();
        @(posedge clk);
        check("post_abort_count", n_win - w0, NPIX);
        repeat (2) @(negedge clk);

        // two frames with no idle gap between them
        w0 = n_win;
        push_frame(1, NPIX);
        drive_frame(1, 1'b0, NPIX, 1'b0);
        check_flush();
        push_frame(1, NPIX);
        drive_frame(1, 1'b0, NPIX, 1'b1);
        check_flush();
        @(posedge clk);
        check("two_frame_count", n_win - w0, 2 * NPIX);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
